calc_req_scheduler: RTL and testbench

Shares one calculator ALU between four request ports. Each port delivers a request over two cycles: cmd with operand1, then operand2. The block captures each request, round-robin arbitrates the pending requests onto the single-issue ALU interface, and routes each ALU result back to the originating port's response outputs. It sits between the top-level request/response pins and the shared add/sub/shift unit inside calc1_top.

---
 rtl/calc_sched_pkg.sv | 37 +++
 rtl/calc_req_scheduler_if.sv | 32 +++
 rtl/calc_port_capture.sv | 88 ++++++++
 rtl/calc_req_scheduler.sv | 103 ++++++++++
 tb/tb_calc_req_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_sched_pkg.sv
// Shared types and constants for the four-port calculator request scheduler.
package calc_sched_pkg;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 32;
  localparam int RESP_W = 2;
  localparam int TAG_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    OP2,
    PEND,
    BUSY,
    INVAL
  } port_state_t;

  localparam logic [RESP_W-1:0] RESP_NONE  = 2'b00;
  localparam logic [RESP_W-1:0] RESP_OK    = 2'b01;
  localparam logic [RESP_W-1:0] RESP_ERR   = 2'b10;
  localparam logic [RESP_W-1:0] RESP_INVAL = 2'b11;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } calc_req_t;

  function automatic logic cmd_is_valid(input logic [CMD_W-1:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc_req_scheduler_if.sv
// Request/response pins and the shared-ALU issue/return bus of the scheduler.
interface calc_req_scheduler_if #(
  parameter int NUM_PORTS = 4
);
  import calc_sched_pkg::*;

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic                        alu_valid;
  logic [CMD_W-1:0]            alu_cmd;
  logic [DATA_W-1:0]           alu_op1;
  logic [DATA_W-1:0]           alu_op2;
  logic [TAG_W-1:0]            alu_tag;
  logic                        alu_done;
  logic [RESP_W-1:0]           alu_resp;
  logic [DATA_W-1:0]           alu_data;
  logic [TAG_W-1:0]            alu_done_tag;
  logic                        sched_err;

  modport master (
    input  req_cmd_in, req_data_in, alu_done, alu_resp, alu_data, alu_done_tag,
    output out_resp, out_data, alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, sched_err
  );

  modport slave (
    output req_cmd_in, req_data_in, alu_done, alu_resp, alu_data, alu_done_tag,
    input  out_resp, out_data, alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, sched_err
  );

endinterface

// File: rtl/calc_port_capture.sv
// One request port: two-cycle capture, wait for grant, wait for result or timeout,
// then a single-cycle registered response pulse.
module calc_port_capture
  import calc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  input  logic              done_hit,
  input  logic [RESP_W-1:0] alu_resp,
  input  logic [DATA_W-1:0] alu_data,
  output logic              pend,
  output logic              busy,
  output logic              expire,
  output calc_req_t         req,
  output logic [RESP_W-1:0] resp,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  port_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // A result arriving on the expiry edge takes priority over the abort.
  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      IDLE:  if (cmd != '0) state_d = OP2;
      OP2:   state_d = cmd_is_valid(req.cmd) ? PEND : INVAL;
      INVAL: state_d = IDLE;
      PEND:  if (grant) state_d = BUSY;
      BUSY: begin
        if (done_hit) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      req   <= '0;
      cnt_q <= '0;
      resp  <= RESP_NONE;
      rdata <= '0;
    end else begin
      resp  <= RESP_NONE;
      rdata <= '0;
      if (state_q == IDLE && cmd != '0) begin
        req.cmd <= cmd;
        req.op1 <= data;
      end
      if (state_q == OP2) begin
        req.op2 <= data;
        if (!cmd_is_valid(req.cmd)) resp <= RESP_INVAL;
      end
      if (grant)                cnt_q <= '0;
      else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      if (state_q == BUSY && done_hit) begin
        resp  <= alu_resp;
        rdata <= alu_data;
      end else if (expire) begin
        resp  <= RESP_INVAL;
        rdata <= '1;
      end
    end
  end

  assign pend = (state_q == PEND);
  assign busy = (state_q == BUSY);

endmodule

// File: rtl/calc_req_scheduler.sv
// Shares one single-issue calculator ALU among NUM_PORTS request ports with
// round-robin arbitration and tag-based result routing.
module calc_req_scheduler
  import calc_sched_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  c_clk,
  input logic                  reset,
  calc_req_scheduler_if.master bus
);

  logic [NUM_PORTS-1:0] pend, busy, expire, grant, done_hit;
  calc_req_t            req   [NUM_PORTS];
  logic [RESP_W-1:0]    resp  [NUM_PORTS];
  logic [DATA_W-1:0]    rdata [NUM_PORTS];

  logic             alu_busy, eligible, grant_any;
  logic [TAG_W-1:0] last_grant, grant_idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign done_hit[p] = bus.alu_done && (bus.alu_done_tag == TAG_W'(p));

    calc_port_capture #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_port (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd      (bus.req_cmd_in[CMD_W*p +: CMD_W]),
      .data     (bus.req_data_in[DATA_W*p +: DATA_W]),
      .grant    (grant[p]),
      .done_hit (done_hit[p]),
      .alu_resp (bus.alu_resp),
      .alu_data (bus.alu_data),
      .pend     (pend[p]),
      .busy     (busy[p]),
      .expire   (expire[p]),
      .req      (req[p]),
      .resp     (resp[p]),
      .rdata    (rdata[p])
    );
  end

  always_comb begin
    bus.out_resp = '0;
    bus.out_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.out_resp[RESP_W*p +: RESP_W] = resp[p];
      bus.out_data[DATA_W*p +: DATA_W] = rdata[p];
    end
  end

  // Rotating search starting one past the previous winner.
  always_comb begin
    int idx;
    idx       = 0;
    eligible  = !alu_busy || bus.alu_done;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = last_grant;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (eligible && !grant_any && pend[idx]) begin
        grant_any = 1'b1;
        grant_idx = TAG_W'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      alu_busy      <= 1'b0;
      last_grant    <= TAG_W'(NUM_PORTS - 1);
      bus.alu_valid <= 1'b0;
      bus.alu_cmd   <= '0;
      bus.alu_op1   <= '0;
      bus.alu_op2   <= '0;
      bus.alu_tag   <= '0;
      bus.sched_err <= 1'b0;
    end else begin
      bus.alu_valid <= grant_any;
      if (grant_any) begin
        bus.alu_cmd <= req[grant_idx].cmd;
        bus.alu_op1 <= req[grant_idx].op1;
        bus.alu_op2 <= req[grant_idx].op2;
        bus.alu_tag <= grant_idx;
        last_grant  <= grant_idx;
      end else begin
        bus.alu_cmd <= '0;
        bus.alu_op1 <= '0;
        bus.alu_op2 <= '0;
        bus.alu_tag <= '0;
      end
      if (grant_any)                     alu_busy <= 1'b1;
      else if (bus.alu_done || |expire)  alu_busy <= 1'b0;
      // Results for a port that is no longer waiting are dropped but remembered.
      if (bus.alu_done && !busy[bus.alu_done_tag]) bus.sched_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Scoreboard bench for calc_req_scheduler with a one-cycle-latency ALU model.
module tb_calc_req_scheduler;
  import calc_sched_pkg::*;

  localparam int NP = 4;
  localparam int TO = 16;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  calc_req_scheduler_if #(.NUM_PORTS(NP)) bus ();

  calc_req_scheduler #(
    .NUM_PORTS(NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } disp_t;

  disp_t       exp_disp [$];
  logic [33:0] exp_resp [NP][$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int send_cyc = 0;
  int last_valid_cyc = 0;
  int valid_count = 0;
  int last_resp_cyc [NP];
  bit prev_nz [NP];
  bit inflight = 1'b0;
  bit model_en = 1'b1;
  bit stray_req = 1'b0;
  logic [1:0]  stray_tag = '0;
  bit          m_pend = 1'b0;
  logic [3:0]  m_cmd;
  logic [31:0] m_op1, m_op2;
  logic [1:0]  m_tag;
  disp_t       mon_e;
  logic [33:0] mon_r;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    case (c)
      CMD_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        return {(s[32] ? RESP_ERR : RESP_OK), s[31:0]};
      end
      CMD_SUB: return {((a < b) ? RESP_ERR : RESP_OK), a - b};
      CMD_SHL: return {RESP_OK, a << b[4:0]};
      CMD_SHR: return {RESP_OK, a >> b[4:0]};
      default: return {RESP_INVAL, 32'h0};
    endcase
  endfunction

  function automatic int pending();
    int n = exp_disp.size();
    for (int p = 0; p < NP; p++) n += exp_resp[p].size();
    return n;
  endfunction

  // ALU model: answers one cycle after the dispatch cycle.
  always @(posedge c_clk) begin
    logic [33:0] res;
    #1;
    if (m_pend && model_en) begin
      res = alu_ref(m_cmd, m_op1, m_op2);
      bus.alu_done     = 1'b1;
      bus.alu_resp     = res[33:32];
      bus.alu_data     = res[31:0];
      bus.alu_done_tag = m_tag;
      inflight         = 1'b0;
    end else if (stray_req) begin
      bus.alu_done     = 1'b1;
      bus.alu_resp     = RESP_OK;
      bus.alu_data     = 32'h1234;
      bus.alu_done_tag = stray_tag;
    end else begin
      bus.alu_done     = 1'b0;
      bus.alu_resp     = '0;
      bus.alu_data     = '0;
      bus.alu_done_tag = '0;
    end
    m_pend = 1'b0;
  end

  always @(negedge c_clk) begin
    if (!reset) begin
      if (bus.alu_valid) begin
        valid_count++;
        last_valid_cyc = cyc;
        chk("disp_overlap", 64'(inflight), 64'(0));
        inflight = 1'b1;
        m_pend = 1'b1;
        m_cmd = bus.alu_cmd;
        m_op1 = bus.alu_op1;
        m_op2 = bus.alu_op2;
        m_tag = bus.alu_tag;
        if (exp_disp.size() == 0) chk("disp_unexpected", 64'(1), 64'(0));
        else begin
          mon_e = exp_disp.pop_front();
          chk("disp_cmd_tag", 64'({bus.alu_cmd, bus.alu_tag}), 64'({mon_e.cmd, mon_e.tag}));
          chk("disp_ops", {bus.alu_op1, bus.alu_op2}, {mon_e.op1, mon_e.op2});
        end
      end else if (bus.alu_cmd != '0 || bus.alu_op1 != '0 || bus.alu_op2 != '0 ||
                   bus.alu_tag != '0) begin
        chk("disp_idle_zero", 64'(1), 64'(0));
      end
      for (int p = 0; p < NP; p++) begin
        mon_r = {bus.out_resp[2*p +: 2], bus.out_data[32*p +: 32]};
        if (mon_r[33:32] != 2'b00) begin
          if (prev_nz[p]) chk($sformatf("pulse_len_p%0d", p), 64'(1), 64'(0));
          if (exp_resp[p].size() == 0)
            chk($sformatf("resp_unexpected_p%0d", p), 64'(mon_r), 64'(0));
          else
            chk($sformatf("resp_p%0d", p), 64'(mon_r), 64'(exp_resp[p].pop_front()));
          last_resp_cyc[p] = cyc;
          prev_nz[p] = 1'b1;
        end else begin
          if (mon_r[31:0] != '0) chk($sformatf("data_idle_p%0d", p), 64'(mon_r), 64'(0));
          prev_nz[p] = 1'b0;
        end
      end
    end
  end

  // mode 0: normal, 1: expect timeout abort, 2: expect dispatch only
  task automatic send(input logic [3:0] mask, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input int mode);
    @(posedge c_clk); #1;
    send_cyc = cyc;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        bus.req_cmd_in[4*p +: 4]   = c;
        bus.req_data_in[32*p +: 32] = a;
        if (cmd_is_valid(c)) begin
          exp_disp.push_back({c, a, b, 2'(p)});
          if (mode == 0)      exp_resp[p].push_back(alu_ref(c, a, b));
          else if (mode == 1) exp_resp[p].push_back({RESP_INVAL, 32'hFFFF_FFFF});
        end else begin
          exp_resp[p].push_back({RESP_INVAL, 32'h0});
        end
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        bus.req_cmd_in[4*p +: 4]   = '0;
        bus.req_data_in[32*p +: 32] = b;
      end
    end
    @(posedge c_clk); #1;
    bus.req_data_in = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge c_clk);
      n++;
    end
    repeat (3) @(posedge c_clk);
    #1;
    chk(tag, 64'(pending()), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge c_clk); #1;
    reset = 1'b1;
    inflight = 1'b0;
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int vc;
    int n;
    bus.req_cmd_in   = '0;
    bus.req_data_in  = '0;
    bus.alu_done     = 1'b0;
    bus.alu_resp     = '0;
    bus.alu_data     = '0;
    bus.alu_done_tag = '0;
    for (int p = 0; p < NP; p++) begin
      last_resp_cyc[p] = 0;
      prev_nz[p] = 1'b0;
    end
    repeat (3) @(posedge c_clk);
    #1;
    chk("rst_valid", 64'(bus.alu_valid), 64'(0));
    chk("rst_resp", 64'(bus.out_resp), 64'(0));
    chk("rst_data", 64'(|bus.out_data), 64'(0));
    chk("rst_err", 64'(bus.sched_err), 64'(0));
    reset = 1'b0;

    // single add on port 0
    send(4'b0001, CMD_ADD, 32'd5, 32'd1, 0);
    drain("t1_drain", 40);
    chk("t1_disp_lat", 64'(last_valid_cyc - send_cyc), 64'(3));
    chk("t1_resp_lat", 64'(last_resp_cyc[0] - last_valid_cyc), 64'(2));

    // four simultaneous subtracts, two rounds, rotation from a fresh reset
    do_reset();
    send(4'b1111, CMD_SUB, 32'd9, 32'd4, 0);
    drain("t2_drain_a", 60);
    send(4'b1111, CMD_SUB, 32'd9, 32'd4, 0);
    drain("t2_drain_b", 60);

    // invalid command on port 2
    vc = valid_count;
    send(4'b0100, 4'd3, 32'd7, 32'd7, 0);
    drain("t3_drain", 20);
    chk("t3_no_disp", 64'(valid_count - vc), 64'(0));
    chk("t3_resp_lat", 64'(last_resp_cyc[2] - send_cyc), 64'(2));

    // overflow passthrough on port 3
    send(4'b1000, CMD_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    drain("t4_drain", 40);

    // silent ALU: timeout on port 1, then a late stray result
    model_en = 1'b0;
    send(4'b0010, CMD_ADD, 32'd1, 32'd2, 1);
    drain("t5_drain", 60);
    chk("t5_timeout_lat", 64'(last_resp_cyc[1] - last_valid_cyc), 64'(TO));
    inflight = 1'b0;
    chk("t5_err_before", 64'(bus.sched_err), 64'(0));
    @(negedge c_clk);
    stray_tag = 2'd1;
    stray_req = 1'b1;
    @(negedge c_clk);
    stray_req = 1'b0;
    repeat (3) @(posedge c_clk);
    #1;
    chk("t5_sched_err", 64'(bus.sched_err), 64'(1));

    // reset in the dispatch cycle while port 0 is busy
    vc = valid_count;
    send(4'b0001, CMD_ADD, 32'd2, 32'd3, 2);
    n = 0;
    do begin
      @(negedge c_clk); #1;
      n++;
    end while (valid_count == vc && n < 20);
    chk("t6_in_dispatch", 64'(bus.alu_valid), 64'(1));
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.alu_valid), 64'(0));
    chk("t6_rst_disp", 64'({bus.alu_cmd, bus.alu_tag}) | 64'(bus.alu_op1) | 64'(bus.alu_op2),
        64'(0));
    chk("t6_rst_err", 64'(bus.sched_err), 64'(0));
    chk("t6_rst_resp", 64'(bus.out_resp), 64'(0));
    chk("t6_rst_data", 64'(|bus.out_data), 64'(0));
    inflight = 1'b0;
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b0;
    model_en = 1'b1;
    send(4'b0001, CMD_ADD, 32'd2, 32'd3, 0);
    drain("t6_drain", 40);
    chk("t6_resp_lat", 64'(last_resp_cyc[0] - last_valid_cyc), 64'(2));
    chk("t6_err_after", 64'(bus.sched_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
